// File: rtl/ram_pkg.sv
// Shared types, read-during-write constants and the byte-merge helper for dual_port_ram.
// byte_merge is only referenced when RAM_WRITE_MASK_EN is defined.
package ram_pkg;

  typedef enum logic {
    RAM_CLEAR = 1'b0,
    RAM_READY = 1'b1
  } ram_state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Wide enough for any practical word; callers zero-extend in and slice the result.
  localparam int MERGE_MAX_W = 256;

  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]   old_word,
    input logic [MERGE_MAX_W-1:0]   new_word,
    input logic [MERGE_MAX_W/8-1:0] mask
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_MAX_W / 8; i++) begin
      if (mask[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_clear_sequencer.sv
// Reset-time clear sweep: walks addresses 0..DEPTH-1 once, then reports ready.
// With CLEAR_ON_RESET=0 it goes straight to RAM_READY and the sweep never runs.
module ram_clear_sequencer
  import ram_pkg::*;
#(
  parameter int A_WIDTH        = 12,
  parameter int DEPTH          = 2 ** A_WIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clock,
  input  logic               reset,
  output logic               clear_active,
  output logic [A_WIDTH-1:0] clear_address,
  output logic               ready
);

  localparam logic [A_WIDTH-1:0] LAST_ADDRESS = A_WIDTH'(DEPTH - 1);
  localparam ram_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_READY;

  ram_state_e         state_reg, state_next;
  logic [A_WIDTH-1:0] counter_reg, counter_next;
  logic               ready_reg;

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    case (state_reg)
      RAM_CLEAR: begin
        if (counter_reg == LAST_ADDRESS) begin
          state_next   = RAM_READY;
          counter_next = '0;
        end else begin
          counter_next = counter_reg + A_WIDTH'(1);
        end
      end
      RAM_READY: begin
        state_next = RAM_READY;
      end
      default: begin
        state_next   = RESET_STATE;
        counter_next = '0;
      end
    endcase
  end

  // ready rises on the same edge that writes the last word of the sweep.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= RESET_STATE;
      counter_reg <= '0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      ready_reg   <= (state_next == RAM_READY);
    end
  end

  assign clear_active  = (state_reg == RAM_CLEAR);
  assign clear_address = counter_reg;
  assign ready         = ready_reg;

endmodule

// File: rtl/dual_port_ram.sv
// Dual-port RAM: port A read/write, port B read-only, optional reset clear sweep.
// Optional byte-masked writes on port A when RAM_WRITE_MASK_EN is defined.
module dual_port_ram
  import ram_pkg::*;
#(
  parameter int                 D_WIDTH        = 16,
  parameter int                 A_WIDTH        = 12,
  parameter int                 DEPTH          = 2 ** A_WIDTH,
  parameter int                 CLEAR_ON_RESET = 1,
  parameter logic [D_WIDTH-1:0] INIT_VALUE     = '0,
  parameter int                 RDW_MODE       = 0
) (
  input  logic               clock,
  input  logic               reset,
  output logic               ready_out,
  output logic [D_WIDTH-1:0] data_out,
  input  logic [D_WIDTH-1:0] data_in,
  input  logic [A_WIDTH-1:0] address_in,
  input  logic               read_enable_in,
  input  logic               write_enable_in,
`ifdef RAM_WRITE_MASK_EN
  input  logic [D_WIDTH/8-1:0] write_mask_in,
`endif
  output logic [D_WIDTH-1:0] b_data_out,
  input  logic [A_WIDTH-1:0] b_address_in,
  input  logic               b_read_enable_in
);

  localparam logic [A_WIDTH:0] DEPTH_LIMIT = (A_WIDTH + 1)'(DEPTH);
  localparam bit WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

  logic [D_WIDTH-1:0] content [0:DEPTH-1];

  logic               clear_active;
  logic [A_WIDTH-1:0] clear_address;
  logic               ready;
  logic               a_in_range;
  logic               b_in_range;
  logic               a_write;
  logic               b_hits_write;
  logic [D_WIDTH-1:0] write_word;

  ram_clear_sequencer #(
    .A_WIDTH        (A_WIDTH),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_sequencer (
    .clock         (clock),
    .reset         (reset),
    .clear_active  (clear_active),
    .clear_address (clear_address),
    .ready         (ready)
  );

  assign a_in_range   = ({1'b0, address_in} < DEPTH_LIMIT);
  assign b_in_range   = ({1'b0, b_address_in} < DEPTH_LIMIT);
  assign a_write      = ready && write_enable_in && a_in_range;
  assign b_hits_write = a_write && (b_address_in == address_in);

`ifdef RAM_WRITE_MASK_EN
  // Merge against the stored word so write-first forwarding sees the final value.
  logic [MERGE_MAX_W-1:0] merged_full;
  assign merged_full = byte_merge(MERGE_MAX_W'(content[address_in]),
                                  MERGE_MAX_W'(data_in),
                                  (MERGE_MAX_W / 8)'(write_mask_in));
  assign write_word  = merged_full[D_WIDTH-1:0];
`else
  assign write_word  = data_in;
`endif

  // Storage write port; the sweep has priority and accesses are blocked while it runs.
  always_ff @(posedge clock) begin
    if (clear_active && !reset) begin
      content[clear_address] <= INIT_VALUE;
    end else if (a_write) begin
      content[address_in] <= write_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_out   <= '0;
      b_data_out <= '0;
    end else if (ready) begin
      if (read_enable_in) begin
        if (!a_in_range) begin
          data_out <= '0;
        end else if (WRITE_FIRST && a_write) begin
          data_out <= write_word;
        end else begin
          data_out <= content[address_in];
        end
      end
      if (b_read_enable_in) begin
        if (!b_in_range) begin
          b_data_out <= '0;
        end else if (WRITE_FIRST && b_hits_write) begin
          b_data_out <= write_word;
        end else begin
          b_data_out <= content[b_address_in];
        end
      end
    end
  end

  assign ready_out = ready;

endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
Parametrised successor to the single-port Mano memory. It adds a second, read-only port for instruction fetch or debug alongside the read/write port A. It also adds a synchronous-reset clear sequencer and a selectable read-during-write mode. It sits between the CPU datapath (port A), the fetch/monitor logic (port B) and the bench, which preloads the `content` array hierarchically.

Parameters:
D_WIDTH, 16, word width in bits; must be a multiple of 8 when RAM_WRITE_MASK_EN is defined
A_WIDTH, 12, address width in bits
DEPTH, 2**A_WIDTH, implemented words; 1 <= DEPTH <= 2**A_WIDTH
CLEAR_ON_RESET, 1, 1 = reset sweeps every word to INIT_VALUE; 0 = reset preserves contents
INIT_VALUE, 0, D_WIDTH-bit value written by the clear sweep
RDW_MODE, 0, 0 = read-first (old data), 1 = write-first (new data)

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high
ready_out  out  1  high when ports accept accesses
data_out  out  D_WIDTH  port A registered read data
data_in  in  D_WIDTH  port A write data
address_in  in  A_WIDTH  port A address
read_enable_in  in  1  port A read strobe
write_enable_in  in  1  port A write strobe
b_data_out  out  D_WIDTH  port B registered read data
b_address_in  in  A_WIDTH  port B address
b_read_enable_in  in  1  port B read strobe

Behaviour:
- Storage: array named `content[0:DEPTH-1]`, hierarchically writable by benches. It carries no initial value; it is X until written or cleared.
- Reset (sampled at posedge): data_out, b_data_out and ready_out are set to 0. The FSM enters CLEAR when CLEAR_ON_RESET=1, otherwise READY. Reset held high keeps these values.
- FSM states are CLEAR and READY.
- CLEAR: a counter starts at 0 and writes INIT_VALUE to content[counter] each cycle. It moves to READY on the cycle after writing DEPTH-1, so the sweep takes exactly DEPTH cycles. ready_out rises on that same edge.
- Reset asserted mid-sweep restarts the counter at 0.
- During CLEAR, port A/B strobes are ignored: no writes, and outputs hold 0.
- READY, port A:
  - write_enable_in high: content[address_in] <= data_in at posedge.
  - read_enable_in high: data_out <= content[address_in]. Latency is 1 cycle and the value is visible after the posedge.
  - read_enable_in low: data_out holds its previous value.
- READY, port B: same read rule on b_address_in / b_read_enable_in / b_data_out.
- Simultaneous port A write and read to the same address (A read or B read):
  - RDW_MODE=0 returns the old word.
  - RDW_MODE=1 returns data_in.
- Address >= DEPTH: writes are dropped, reads return 0 and ready_out is unaffected.
- Both ports reading the same address is legal; both get the same word.
- The block never drives X onto outputs except when reading a never-written, uncleared word.

Optional Feature:
- Macro RAM_WRITE_MASK_EN.
- Defined: adds port write_mask_in (in, D_WIDTH/8). A write updates only the bytes whose mask bit is 1 (bit i covers data bits 8i+7:8i). RDW_MODE=1 forwards the merged word. The clear sweep ignores the mask.
- Undefined: the port is absent and writes are full-word.

Decomposition:
- Package ram_pkg:
  - ram_state_e enum {RAM_CLEAR, RAM_READY}.
  - Constants RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1.
  - Function byte_merge(old, new, mask) used under the macro.
- One sub-module, ram_clear_sequencer. It owns the FSM and counter and outputs clear_active, clear_address and ready.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=4096: pulse reset, then poll. ready_out is 0 for 4096 cycles and rises on cycle 4096. Read A 12'h123 gives 16'h0000.
- Assert reset again at sweep cycle 100 and hold for 1 cycle -> ready_out is low for a further 4096 cycles.
- CLEAR_ON_RESET=0, bench sets content[12'h200]=16'h1234. Then reset, then read B 12'h200 -> b_data_out=16'h1234 one cycle later.
- Write A 12'h001=16'h5f5f, then read with A disabled -> data_out is unchanged. Then read A and B at 12'h001 -> both show 16'h5f5f.
- Same-cycle A write 12'h010=16'hf5f5 (old 16'h5f5f) with B read 12'h010 -> RDW_MODE=0 gives b_data_out=16'h5f5f; RDW_MODE=1 gives 16'hf5f5.
- RAM_WRITE_MASK_EN, word 16'h1234, write 16'hABCD with mask 2'b01 -> 16'h12CD. Also DEPTH=3000: write to 12'hC00 is dropped and reading it gives 0.
